// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: counter width, init value and scheduler FSM states.
package bpu_pkg;
    localparam int                 CNT_W       = 2;
    localparam logic [CNT_W-1:0]   CNT_WEAK_NT = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/pht_scheduler_if.sv
// Request/response and update channels of the pattern history table scheduler.
interface pht_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             flush_i;
    logic             pred_valid_i;
    logic [IDX_W-1:0] pred_idx_i;
    logic             pred_ready_o;
    logic             resp_valid_o;
    logic             resp_taken_o;
    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic             upd_ready_o;
    logic             init_busy_o;

    modport slave (
        input  flush_i, pred_valid_i, pred_idx_i, upd_valid_i, upd_idx_i, upd_taken_i,
        output pred_ready_o, resp_valid_o, resp_taken_o, upd_ready_o, init_busy_o
    );

    modport master (
        output flush_i, pred_valid_i, pred_idx_i, upd_valid_i, upd_idx_i, upd_taken_i,
        input  pred_ready_o, resp_valid_o, resp_taken_o, upd_ready_o, init_busy_o
    );
endinterface

// File: rtl/sat_cnt_next.sv
// Next value of a 2-bit saturating counter after one resolved branch.
module sat_cnt_next
    import bpu_pkg::*;
(
    input  logic [CNT_W-1:0] cur,
    input  logic             taken,
    output logic [CNT_W-1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
    end
endmodule

// File: rtl/pht_scheduler.sv
// Pattern history table with one access per cycle, shared between predictions and
// a 2-deep update FIFO, plus an initialisation sweep after reset or flush.
module pht_scheduler
    import bpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rstn,
    pht_scheduler_if.slave  bus
);
    state_t           r_state;
    logic [IDX_W-1:0] r_init_ptr;
    logic [CNT_W-1:0] r_table [DEPTH];
    logic [IDX_W-1:0] r_fifo_idx [2];
    logic             r_fifo_tk [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_resp_valid;
    logic             r_resp_taken;

    logic             w_run;
    logic             w_full;
    logic             w_pred_fire;
    logic             w_upd_fire;
    logic             w_drain;
    logic [IDX_W-1:0] w_head_idx;
    logic [CNT_W-1:0] w_nxt_cnt;

    assign w_run      = (r_state == RUN);
    assign w_full     = (r_count == 2'd2);
    assign w_head_idx = r_fifo_idx[r_rd_ptr];

    // A full FIFO always wins the table port; otherwise predictions take priority.
    assign w_pred_fire = w_run && !w_full && bus.pred_valid_i && !bus.flush_i;
    assign w_upd_fire  = w_run && !w_full && bus.upd_valid_i  && !bus.flush_i;
    assign w_drain     = w_run && !bus.flush_i &&
                         (w_full || (!bus.pred_valid_i && (r_count != 2'd0)));

    assign bus.pred_ready_o = w_run && !w_full;
    assign bus.upd_ready_o  = w_run && !w_full;
    assign bus.init_busy_o  = (r_state == INIT);
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_taken_o = r_resp_taken;

    sat_cnt_next u_sat (
        .cur   (r_table[w_head_idx]),
        .taken (r_fifo_tk[r_rd_ptr]),
        .nxt   (w_nxt_cnt)
    );

    // Table and FIFO payload carry no reset; the sweep defines the table contents.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_table[r_init_ptr] <= CNT_WEAK_NT;
        end else if (w_drain) begin
            r_table[w_head_idx] <= w_nxt_cnt;
        end
        if (w_upd_fire) begin
            r_fifo_idx[r_wr_ptr] <= bus.upd_idx_i;
            r_fifo_tk[r_wr_ptr]  <= bus.upd_taken_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= INIT;
            r_init_ptr   <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_resp_valid <= 1'b0;
            r_resp_taken <= 1'b0;
        end else if (bus.flush_i) begin
            r_state      <= INIT;
            r_init_ptr   <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_resp_valid <= 1'b0;
            r_resp_taken <= 1'b0;
        end else begin
            r_resp_valid <= w_pred_fire;
            r_resp_taken <= w_pred_fire ? r_table[bus.pred_idx_i][1] : 1'b0;
            case (r_state)
                INIT: begin
                    r_init_ptr <= r_init_ptr + IDX_W'(1);
                    if (r_init_ptr == IDX_W'(DEPTH - 1)) r_state <= RUN;
                end
                RUN: begin
                    if (w_upd_fire) r_wr_ptr <= ~r_wr_ptr;
                    if (w_drain)    r_rd_ptr <= ~r_rd_ptr;
                    case ({w_upd_fire, w_drain})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                end
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pht_scheduler.sv
// Self-checking bench: model table updated at update acceptance, response queue checked per cycle.
module tb_pht_scheduler;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pht_scheduler_if #(.IDX_W(4)) bus ();

    pht_scheduler #(.DEPTH(16), .IDX_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] model [16];
    logic exp_q [$];

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 16; i++) model[i] = 2'b01;
        exp_q.delete();
    endtask

    // Drives one cycle from a negedge and returns at the next negedge.
    task automatic step(input logic pv, input logic [3:0] pi, input logic uv,
                        input logic [3:0] ui, input logic ut,
                        output logic pacc, output logic uacc);
        bus.flush_i      = 1'b0;
        bus.pred_valid_i = pv;
        bus.pred_idx_i   = pi;
        bus.upd_valid_i  = uv;
        bus.upd_idx_i    = ui;
        bus.upd_taken_i  = ut;
        pacc = pv && bus.pred_ready_o;
        uacc = uv && bus.upd_ready_o;
        if (pacc) exp_q.push_back(model[pi][1]);
        if (uacc) model[ui] = sat(model[ui], ut);
        @(negedge clk);
        bus.pred_valid_i = 1'b0;
        bus.upd_valid_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        logic pa, ua;
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, pa, ua);
    endtask

    task automatic test_reset();
        logic pa, ua, e;
        int   cnt;
        bus.flush_i = 0; bus.pred_valid_i = 0; bus.pred_idx_i = 0;
        bus.upd_valid_i = 0; bus.upd_idx_i = 0; bus.upd_taken_i = 0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 10000",
                     {bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o});
        end
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40 && bus.init_busy_o; k++) begin cnt++; @(negedge clk); end
        n_cmp++;
        if (cnt !== 16) begin n_err++; $display("FAIL reset_sweep_len: got %0d cycles expected 16", cnt); end
        model_init();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, pa, ua);
            n_cmp++;
            if (bus.resp_valid_o !== 1'b1) begin n_err++; $display("FAIL reset_pred_valid[%0d]: got %b expected 1", i, bus.resp_valid_o); end
            else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.resp_taken_o !== e) begin n_err++; $display("FAIL reset_pred_taken[%0d]: got %b expected %b", i, bus.resp_taken_o, e); end
            end
            $display("reset pred idx=%0d taken=%b", i, bus.resp_taken_o);
        end
    endtask

    task automatic test_saturate();
        // 2'b11 taken update, 2'b10 not-taken update, 2'b01 predict
        logic [1:0] ops [16] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10, 2'b01,
                                 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
        logic pa, ua, e;
        for (int i = 0; i < 16; i++) begin
            if (ops[i] == 2'b01) begin
                idle(1);
                step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, pa, ua);
                n_cmp++;
                if (bus.resp_valid_o !== 1'b1) begin n_err++; $display("FAIL sat_pred_valid[%0d]: got %b expected 1", i, bus.resp_valid_o); end
                else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (bus.resp_taken_o !== e) begin n_err++; $display("FAIL sat_pred_taken[%0d]: got %b expected %b", i, bus.resp_taken_o, e); end
                end
                $display("sat pred idx=5 taken=%b model=%0d", bus.resp_taken_o, model[5]);
            end else begin
                step(1'b0, 4'd0, 1'b1, 4'd5, ops[i][0], pa, ua);
                n_cmp++;
                if (ua !== 1'b1) begin n_err++; $display("FAIL sat_upd_accept[%0d]: got %b expected 1", i, ua); end
                $display("sat upd idx=5 taken=%b", ops[i][0]);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ui [3] = '{4'd9, 4'd10, 4'd9};
        logic       ut [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] chk [2] = '{4'd9, 4'd10};
        logic pa, ua, e;
        int   n = 0, low_run = 0, max_low = 0;
        for (int c = 0; c < 12 && n < 3; c++) begin
            step(1'b1, 4'd2, 1'b1, ui[n], ut[n], pa, ua);
            if (ua) n++;
            if (!pa) begin low_run++; if (low_run > max_low) max_low = low_run; end
            else low_run = 0;
            n_cmp++;
            if (bus.resp_valid_o !== pa) begin n_err++; $display("FAIL b2b_resp_valid: got %b expected %b", bus.resp_valid_o, pa); end
            else if (pa) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.resp_taken_o !== e) begin n_err++; $display("FAIL b2b_pred_taken: got %b expected %b", bus.resp_taken_o, e); end
            end
            $display("b2b cycle=%0d pred_acc=%b upd_acc=%b", c, pa, ua);
        end
        n_cmp++;
        if (n !== 3) begin n_err++; $display("FAIL b2b_upd_count: got %0d expected 3", n); end
        n_cmp++;
        if (max_low < 1 || max_low > 2) begin n_err++; $display("FAIL b2b_stall: got %0d cycles expected 1..2", max_low); end
        idle(3);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, chk[i], 1'b0, 4'd0, 1'b0, pa, ua);
            n_cmp++;
            e = exp_q.pop_front();
            if (bus.resp_valid_o !== 1'b1 || bus.resp_taken_o !== e) begin
                n_err++;
                $display("FAIL b2b_final[%0d]: got valid=%b taken=%b expected valid=1 taken=%b", chk[i], bus.resp_valid_o, bus.resp_taken_o, e);
            end
            $display("b2b final idx=%0d taken=%b", chk[i], bus.resp_taken_o);
        end
    endtask

    task automatic test_no_bypass();
        logic pa, ua, e;
        step(1'b1, 4'd0, 1'b1, 4'd12, 1'b1, pa, ua);
        if (pa) void'(exp_q.pop_front());
        step(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, pa, ua);
        n_cmp++;
        if (pa !== 1'b1 || ua !== 1'b1) begin n_err++; $display("FAIL nobyp_accept: got pred=%b upd=%b expected 1 1", pa, ua); end
        if (pa) void'(exp_q.pop_front());
        n_cmp++;
        if (bus.resp_valid_o !== 1'b1 || bus.resp_taken_o !== 1'b0) begin
            n_err++;
            $display("FAIL nobyp_old_value: got valid=%b taken=%b expected valid=1 taken=0", bus.resp_valid_o, bus.resp_taken_o);
        end
        $display("nobyp pred idx=7 same-cycle taken=%b", bus.resp_taken_o);
        idle(3);
        step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, pa, ua);
        n_cmp++;
        e = exp_q.pop_front();
        if (bus.resp_valid_o !== 1'b1 || bus.resp_taken_o !== e) begin
            n_err++;
            $display("FAIL nobyp_new_value: got valid=%b taken=%b expected valid=1 taken=%b", bus.resp_valid_o, bus.resp_taken_o, e);
        end
        $display("nobyp pred idx=7 later taken=%b", bus.resp_taken_o);
    endtask

    task automatic test_flush();
        logic pa, ua, e;
        int   cnt;
        step(1'b1, 4'd0, 1'b1, 4'd3, 1'b1, pa, ua);
        step(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, pa, ua);
        n_cmp++;
        if (bus.upd_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_fifo_full: got upd_ready=%b expected 0", bus.upd_ready_o); end
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_cmp++;
        if (bus.resp_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_resp_valid: got %b expected 0", bus.resp_valid_o); end
        cnt = 0;
        for (int k = 0; k < 40 && bus.init_busy_o; k++) begin cnt++; @(negedge clk); end
        n_cmp++;
        if (cnt !== 16) begin n_err++; $display("FAIL flush_sweep_len: got %0d cycles expected 16", cnt); end
        model_init();
        idle(3);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, pa, ua);
            n_cmp++;
            e = exp_q.pop_front();
            if (bus.resp_valid_o !== 1'b1 || bus.resp_taken_o !== e) begin
                n_err++;
                $display("FAIL flush_pred[%0d]: got valid=%b taken=%b expected valid=1 taken=%b", i, bus.resp_valid_o, bus.resp_taken_o, e);
            end
            $display("flush pred idx=%0d taken=%b", i, bus.resp_taken_o);
        end
    endtask

    task automatic test_reset_mid();
        logic pa, ua, e;
        int   cnt;
        step(1'b1, 4'd0, 1'b1, 4'd4, 1'b1, pa, ua);
        step(1'b1, 4'd0, 1'b1, 4'd4, 1'b1, pa, ua);
        n_cmp++;
        if (bus.resp_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_pre_resp: got %b expected 1", bus.resp_valid_o); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o} !== 5'b10000) begin
            n_err++;
            $display("FAIL rmid_run_async: got %b expected 10000",
                     {bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o});
        end
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40 && bus.init_busy_o; k++) begin cnt++; @(negedge clk); end
        n_cmp++;
        if (cnt !== 16) begin n_err++; $display("FAIL rmid_run_sweep_len: got %0d cycles expected 16", cnt); end
        model_init();
        idle(3);
        step(1'b1, 4'd4, 1'b0, 4'd0, 1'b0, pa, ua);
        n_cmp++;
        e = exp_q.pop_front();
        if (bus.resp_valid_o !== 1'b1 || bus.resp_taken_o !== e) begin
            n_err++;
            $display("FAIL rmid_lost_update: got valid=%b taken=%b expected valid=1 taken=%b", bus.resp_valid_o, bus.resp_taken_o, e);
        end
        $display("rmid pred idx=4 taken=%b", bus.resp_taken_o);
        // Reset again, then interrupt the sweep once entry 9 is next.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o} !== 5'b10000) begin
            n_err++;
            $display("FAIL rmid_sweep_async: got %b expected 10000",
                     {bus.init_busy_o, bus.pred_ready_o, bus.upd_ready_o, bus.resp_valid_o, bus.resp_taken_o});
        end
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40 && bus.init_busy_o; k++) begin cnt++; @(negedge clk); end
        n_cmp++;
        if (cnt !== 16) begin n_err++; $display("FAIL rmid_sweep_restart_len: got %0d cycles expected 16", cnt); end
        $display("rmid sweep restart length=%0d", cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_saturate();
        test_back_to_back();
        test_no_bypass();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pht_scheduler.md
PHT_SCHEDULER -- requirements
Module: pht_scheduler

Interface
REQ-001 Parameter DEPTH, default 16: number of 2-bit counter entries (power of 2, >=4).
REQ-002 Parameter IDX_W, default 4: index width, equals log2(DEPTH).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  restart table initialisation.
REQ-006 pred_valid_i  input  1  prediction request valid.
REQ-007 pred_idx_i  input  IDX_W  prediction table index.
REQ-008 pred_ready_o  output  1  prediction request accepted when high with pred_valid_i.
REQ-009 resp_valid_o  output  1  prediction result valid.
REQ-010 resp_taken_o  output  1  predicted direction, 1 = taken.
REQ-011 upd_valid_i  input  1  resolved-branch update valid.
REQ-012 upd_idx_i  input  IDX_W  update table index.
REQ-013 upd_taken_i  input  1  resolved direction, 1 = taken.
REQ-014 upd_ready_o  output  1  update accepted when high with upd_valid_i.
REQ-015 init_busy_o  output  1  high while the table is being initialised.

Function
REQ-016 The block SHALL hold DEPTH 2-bit saturating counters; a single table access (read or read-modify-write) occurs per cycle.
REQ-017 FSM: INIT, RUN. INIT writes 2'b01 to entry init_ptr each cycle and increments init_ptr; after writing entry DEPTH-1, the FSM moves to RUN on the next edge, so INIT lasts exactly DEPTH cycles.
REQ-018 In INIT: pred_ready_o=0, upd_ready_o=0, init_busy_o=1; pred/upd inputs are ignored.
REQ-019 flush_i=1 in any state: next state INIT, init_ptr=0, update FIFO emptied, resp_valid_o=0 next cycle; flush_i during INIT restarts the sweep from entry 0.
REQ-020 Updates enter a 2-entry FIFO {idx, taken}; upd_ready_o = RUN and FIFO not full.
REQ-021 pred_ready_o = RUN and FIFO not full.
REQ-022 RUN arbitration per cycle: FIFO full -> drain head; else pred_valid_i -> serve prediction; else FIFO non-empty -> drain head; else idle.
REQ-023 Drain: counter[idx] <- taken ? min(cnt+1, 3) : max(cnt-1, 0); 3 and taken -> 3; 0 and not-taken -> 0.
REQ-024 Prediction handshake in cycle N: resp_valid_o=1 and resp_taken_o=counter[pred_idx_i][1] as sampled in cycle N, both registered and visible in cycle N+1; otherwise resp_valid_o=0 and resp_taken_o=0.
REQ-025 Predictions SHALL NOT bypass queued updates; a pending same-index update is not reflected in the response.
REQ-026 Simultaneous update accept and drain in one cycle SHALL leave FIFO occupancy unchanged and preserve order.
REQ-027 Any update is applied within 3 cycles of acceptance, since a full FIFO forces draining; prediction starvation is bounded by 2 cycles.

Reset
REQ-028 On rstn low: state=INIT, init_ptr=0, FIFO empty, pred_ready_o=0, upd_ready_o=0, resp_valid_o=0, resp_taken_o=0, init_busy_o=1; table contents are undefined until the INIT sweep completes.
REQ-029 Reset asserted mid-sweep or mid-RUN SHALL discard all queued updates and restart the sweep after release.

Structure
REQ-030 Shared package bpu_pkg holds CNT_W=2, CNT_WEAK_NT=2'b01, and the FSM state enum {INIT, RUN}.
REQ-031 The saturating next-value logic SHALL be the combinational sub-module sat_cnt_next (cur[1:0], taken -> nxt[1:0]).

Verification
REQ-032 Reset release -> init_busy_o=1 for 16 cycles, then 0; every entry then predicts not-taken (counter 01).
REQ-033 Three taken updates to idx 5, then predict idx 5 -> resp_taken_o=1 with counter=3; a fourth taken leaves it at 3; four not-taken updates give 0, and a fifth leaves it at 0.
REQ-034 Predict idx 2 every cycle while issuing 3 back-to-back updates -> FIFO fills, pred_ready_o drops for at most 2 cycles, and all updates are applied in order.
REQ-035 Update idx 7 taken accepted in cycle N, predict idx 7 in cycle N with FIFO non-empty -> response reflects the old value (0), and a later predict returns 1.
REQ-036 flush_i pulse with 2 queued updates -> FIFO emptied, 16-cycle sweep, all entries 01, queued updates lost.
REQ-037 rstn asserted at sweep entry 9 -> outputs immediately at reset values; after release the full 16-cycle sweep restarts from entry 0.
